uart_rx_data_path: RTL and testbench
====================================

UART_RX_DATA_PATH -- requirements
Module: uart_rx_data_path

Interface
REQ-001 Parameter OVERSAMPLE, default 16: number of tick16_i pulses per bit period; legal values are 8 and 16.
REQ-002 clk_i  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-003 rst_ni  in  1  asynchronous, active-low reset.
REQ-004 tick16_i  in  1  one-clk oversample enable, at OVERSAMPLE x baud, with at least 1 idle clk between pulses.
REQ-005 rx_i  in  1  serial line input, asynchronous to clk_i, idles high.
REQ-006 crc_en_i  in  1  CRC field is present in the frame; sampled at start-bit confirmation.
REQ-007 data_o  out  8  last received byte; updated only on data_valid_o.
REQ-008 data_valid_o  out  1  one-clk pulse, frame complete.
REQ-009 parity_err_o, crc_err_o, frame_err_o  out  1 each  status of the last frame; valid with data_valid_o and held until the next pulse.
REQ-010 rx_int_o  out  1  one-clk pulse, one clk after data_valid_o, only if all three error flags are 0.
REQ-011 busy_o  out  1  high in every state except IDLE.

Function
REQ-012 Frame format SHALL be: start(0), 8 data bits LSB first, even parity (^data), 8 CRC bits LSB first when enabled, stop(1).
REQ-013 rx_i SHALL pass through a 2-FF synchronizer before any use.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, CRC, STOP.
REQ-015 IDLE->START on synchronized falling edge (previous sample 1, current sample 0).
REQ-016 START: at tick count OVERSAMPLE/2, the FSM SHALL go to DATA if the line is 0; otherwise it SHALL return to IDLE (glitch) with no outputs pulsed.
REQ-017 DATA/PARITY/CRC/STOP: each bit SHALL be sampled once, every OVERSAMPLE ticks after the start midpoint; a 5-bit bit counter clears on every state change.
REQ-018 DATA->PARITY after 8 bits; PARITY->CRC if the latched crc_en is 1, otherwise PARITY->STOP; CRC->STOP after 8 bits.
REQ-019 In the 8 clks following DATA->PARITY, the byte SHALL be fed to uart_crc_gen one bit per clk, MSB first (data[7] down to data[0]); the CRC SHALL be initialized in START.
REQ-020 The received CRC byte SHALL be compared against crc_o at the STOP sample; crc_err_o = mismatch, and crc_err_o is forced to 0 when the latched crc_en is 0.
REQ-021 parity_err_o = (received parity != ^data).
REQ-022 frame_err_o = (stop sample == 0).
REQ-023 The STOP sample SHALL pulse data_valid_o, latch data_o and the flags, and go to IDLE; a new falling edge SHALL be detected from the next clk.
REQ-024 tick16_i absent: the FSM SHALL hold state; no timeout.
REQ-025 A framing-error frame SHALL still report data_o; when the stop sample is 0, the FSM SHALL wait in IDLE for the line to return to 1 before the next edge detection.

Reset
REQ-026 rst_ni low SHALL force: FSM IDLE, counters 0, data_o 8'h00, all flags and pulses 0, busy_o 0, synchronizer 1'b1.
REQ-027 Reset mid-frame SHALL discard the frame with no data_valid_o or rx_int_o pulse after release.

Structure
REQ-028 A shared package (uart_pkg) SHALL hold the rx state enum, the OVERSAMPLE default and the frame bit counts (DATA_BITS=8, CRC_BITS=8).
REQ-029 The block SHALL instantiate the existing uart_crc_gen as its only sub-module, driven by an active-high reset derived from rst_ni.

Verification
REQ-030 Byte 8'hA5, crc off, parity 0, stop 1 -> data_o=8'hA5, all flags 0, data_valid_o and then rx_int_o pulse once.
REQ-031 Byte 8'h3C, crc on, CRC field produced by the uart_tx_data_path reference model -> crc_err_o=0; the same frame with CRC bit 3 flipped -> crc_err_o=1 and no rx_int_o.
REQ-032 Byte 8'h01 with parity bit 0 -> parity_err_o=1, data_o=8'h01, no rx_int_o.
REQ-033 Stop bit 0 -> frame_err_o=1; the next frame is accepted only after the line returns high.
REQ-034 A 3-tick low glitch in IDLE -> returns to IDLE, busy_o falls, no data_valid_o pulse.
REQ-035 rst_ni asserted during DATA bit 4 -> all outputs 0 immediately; the next full frame 8'h5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions:
//   rx_state_e          receive FSM state encoding
//   OVERSAMPLE_DEFAULT  tick16 pulses per bit period (8 or 16 are legal)
//   DATA_BITS/CRC_BITS  frame field widths
//   CRC_POLY            CRC-8 generator polynomial (x^8 + x^2 + x + 1), init 0
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS          = 8;
  localparam int CRC_BITS           = 8;

  localparam logic [7:0] CRC_POLY   = 8'h07;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_CRC    = 3'd4,
    RX_STOP   = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_crc_gen.sv
// ---------------------------------------------------------------------------
// uart_crc_gen
// Bit-serial CRC-8 (CRC_POLY, init 0x00), one message bit per enabled clk,
// MSB of the message first.
// Ports:
//   clk_i   clock
//   rst_i   asynchronous active-high reset (clears the CRC)
//   init_i  synchronous clear to the initial value, wins over en_i
//   en_i    shift bit_i into the CRC this clk
//   bit_i   message bit
//   crc_o   current CRC remainder
// ---------------------------------------------------------------------------
module uart_crc_gen
  import uart_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       init_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_reg;
  logic       feedback;

  assign feedback = crc_reg[7] ^ bit_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_reg <= 8'h00;
    end else if (init_i) begin
      crc_reg <= 8'h00;
    end else if (en_i) begin
      crc_reg <= {crc_reg[6:0], 1'b0} ^ (feedback ? CRC_POLY : 8'h00);
    end
  end

  assign crc_o = crc_reg;

endmodule

// File: rtl/uart_rx_data_path.sv
// ---------------------------------------------------------------------------
// uart_rx_data_path
// Oversampling UART receiver: start, 8 data bits LSB first, even parity,
// optional CRC-8 byte LSB first, stop.
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   tick16_i      one-clk oversample enable (OVERSAMPLE per bit)
//   rx_i          asynchronous serial input, idles high
//   crc_en_i      frame carries a CRC byte (latched at start confirmation)
//   data_o        last received byte
//   data_valid_o  one-clk pulse at the stop sample
//   parity_err_o  last frame parity mismatch
//   crc_err_o     last frame CRC mismatch (0 when CRC disabled)
//   frame_err_o   last frame stop bit was 0
//   rx_int_o      one-clk pulse after data_valid_o for an error-free frame
//   busy_o        FSM not in IDLE
// ---------------------------------------------------------------------------
module uart_rx_data_path
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
)
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick16_i,
  input  logic       rx_i,
  input  logic       crc_en_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       parity_err_o,
  output logic       crc_err_o,
  output logic       frame_err_o,
  output logic       rx_int_o,
  output logic       busy_o
);

  localparam logic [3:0] HALF_LAST = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] FULL_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [4:0] DATA_LAST = 5'(DATA_BITS - 1);
  localparam logic [4:0] CRC_LAST  = 5'(CRC_BITS - 1);

  rx_state_e  state_reg;
  logic [1:0] rx_sync_reg;
  logic       rx_prev_reg;
  logic [3:0] tick_cnt_reg;
  logic [4:0] bit_cnt_reg;
  logic [7:0] data_sh_reg;
  logic [7:0] crc_rx_reg;
  logic       parity_bit_reg;
  logic       crc_en_reg;
  logic [3:0] feed_cnt_reg;
  logic [7:0] data_reg;
  logic       valid_reg;
  logic       parity_err_reg;
  logic       crc_err_reg;
  logic       frame_err_reg;
  logic       rx_int_reg;

  logic       rx_s;
  logic       sample_pt;
  logic [2:0] feed_idx;
  logic [7:0] crc_val;

  assign rx_s     = rx_sync_reg[1];
  assign feed_idx = 3'(feed_cnt_reg - 4'd1);

  // The start bit is sampled half a bit after the edge; every later bit a
  // full bit period after the previous sample, so all samples land mid-bit.
  always_comb begin
    sample_pt = 1'b0;
    if (tick16_i) begin
      if (state_reg == RX_START) sample_pt = (tick_cnt_reg == HALF_LAST);
      else                       sample_pt = (tick_cnt_reg == FULL_LAST);
    end
  end

  // Received byte is replayed MSB first into the CRC while parity is arriving;
  // 8 clks is far shorter than one bit period, so the CRC is settled by STOP.
  uart_crc_gen u_crc_gen (
    .clk_i  (clk_i),
    .rst_i  (~rst_ni),
    .init_i (state_reg == RX_START),
    .en_i   (feed_cnt_reg != 4'd0),
    .bit_i  (data_sh_reg[feed_idx]),
    .crc_o  (crc_val)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= RX_IDLE;
      rx_sync_reg    <= 2'b11;
      rx_prev_reg    <= 1'b1;
      tick_cnt_reg   <= 4'd0;
      bit_cnt_reg    <= 5'd0;
      data_sh_reg    <= 8'h00;
      crc_rx_reg     <= 8'h00;
      parity_bit_reg <= 1'b0;
      crc_en_reg     <= 1'b0;
      feed_cnt_reg   <= 4'd0;
      data_reg       <= 8'h00;
      valid_reg      <= 1'b0;
      parity_err_reg <= 1'b0;
      crc_err_reg    <= 1'b0;
      frame_err_reg  <= 1'b0;
      rx_int_reg     <= 1'b0;
    end else begin
      rx_sync_reg <= {rx_sync_reg[0], rx_i};
      rx_prev_reg <= rx_s;
      valid_reg   <= 1'b0;
      rx_int_reg  <= valid_reg && !(parity_err_reg || crc_err_reg || frame_err_reg);

      if (feed_cnt_reg != 4'd0) feed_cnt_reg <= feed_cnt_reg - 4'd1;

      // Every state exit happens on a sample, which also restarts the count.
      if (tick16_i && state_reg != RX_IDLE)
        tick_cnt_reg <= sample_pt ? 4'd0 : tick_cnt_reg + 4'd1;

      case (state_reg)
        // A stop sample of 0 leaves the line low; the edge test needs a 1
        // first, so a framing error naturally waits for the line to recover.
        RX_IDLE: begin
          if (rx_prev_reg && !rx_s) state_reg <= RX_START;
        end
        RX_START: begin
          if (sample_pt) begin
            bit_cnt_reg <= 5'd0;
            if (!rx_s) begin
              state_reg  <= RX_DATA;
              crc_en_reg <= crc_en_i;
            end else begin
              state_reg  <= RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (sample_pt) begin
            data_sh_reg <= {rx_s, data_sh_reg[7:1]};
            if (bit_cnt_reg == DATA_LAST) begin
              state_reg    <= RX_PARITY;
              bit_cnt_reg  <= 5'd0;
              feed_cnt_reg <= 4'd8;
            end else begin
              bit_cnt_reg  <= bit_cnt_reg + 5'd1;
            end
          end
        end
        RX_PARITY: begin
          if (sample_pt) begin
            parity_bit_reg <= rx_s;
            bit_cnt_reg    <= 5'd0;
            state_reg      <= crc_en_reg ? RX_CRC : RX_STOP;
          end
        end
        RX_CRC: begin
          if (sample_pt) begin
            crc_rx_reg <= {rx_s, crc_rx_reg[7:1]};
            if (bit_cnt_reg == CRC_LAST) begin
              state_reg   <= RX_STOP;
              bit_cnt_reg <= 5'd0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end
        end
        RX_STOP: begin
          if (sample_pt) begin
            valid_reg      <= 1'b1;
            data_reg       <= data_sh_reg;
            parity_err_reg <= parity_bit_reg ^ (^data_sh_reg);
            crc_err_reg    <= crc_en_reg && (crc_rx_reg != crc_val);
            frame_err_reg  <= !rx_s;
            bit_cnt_reg    <= 5'd0;
            state_reg      <= RX_IDLE;
          end
        end
        default: state_reg <= RX_IDLE;
      endcase
    end
  end

  assign data_o       = data_reg;
  assign data_valid_o = valid_reg;
  assign parity_err_o = parity_err_reg;
  assign crc_err_o    = crc_err_reg;
  assign frame_err_o  = frame_err_reg;
  assign rx_int_o     = rx_int_reg;
  assign busy_o       = (state_reg != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_data_path.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_data_path
// Directed and random frames for uart_rx_data_path. Expected byte, flags and
// interrupt are derived from the frame contents; the CRC reference is a
// GF(2) polynomial remainder of data * x^8 modulo x^8 + x^2 + x + 1.
// ---------------------------------------------------------------------------
module tb_uart_rx_data_path;

  localparam int TICK_DIV = 4;               // clks per tick16 pulse
  localparam int BIT_CLKS = 16 * TICK_DIV;   // clks per bit at OVERSAMPLE=16

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       tick16_i;
  logic       rx_i;
  logic       crc_en_i;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       parity_err_o;
  logic       crc_err_o;
  logic       frame_err_o;
  logic       rx_int_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  int         dv_cnt, int_cnt, dv_cyc, int_cyc;
  logic [7:0] cap_data;
  logic       cap_p, cap_c, cap_f;

  uart_rx_data_path #(.OVERSAMPLE(16)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .tick16_i     (tick16_i),
    .rx_i         (rx_i),
    .crc_en_i     (crc_en_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .parity_err_o (parity_err_o),
    .crc_err_o    (crc_err_o),
    .frame_err_o  (frame_err_o),
    .rx_int_o     (rx_int_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
    end
  end

  // One tick16 pulse every TICK_DIV clks.
  initial begin
    int tcnt;
    tcnt = 0;
    tick16_i = 1'b0;
    forever begin
      @(negedge clk_i);
      tcnt++;
      tick16_i = (tcnt % TICK_DIV == 0);
    end
  end

  // Pulse monitor, sampled away from the active edge.
  initial begin
    dv_cnt = 0; int_cnt = 0; dv_cyc = 0; int_cyc = 0;
    cap_data = 8'h00; cap_p = 1'b0; cap_c = 1'b0; cap_f = 1'b0;
    forever begin
      @(negedge clk_i);
      if (data_valid_o === 1'b1) begin
        dv_cnt++;
        dv_cyc   = cyc;
        cap_data = data_o;
        cap_p    = parity_err_o;
        cap_c    = crc_err_o;
        cap_f    = frame_err_o;
      end
      if (rx_int_o === 1'b1) begin
        int_cnt++;
        int_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_crc(input logic [7:0] d);
    logic [15:0] v;
    v = {d, 8'h00};
    for (int i = 15; i >= 8; i--)
      if (v[i]) v = v ^ (16'h0107 << (i - 8));
    return v[7:0];
  endfunction

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (BIT_CLKS) @(negedge clk_i);
  endtask

  // Sends one frame (optionally corrupted), leaves the line low for hold_low
  // extra clks when the stop bit is 0, then idles high for one bit period.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic crc_on,
                           input logic par_flip, input logic [7:0] crc_mask,
                           input logic stop_b, input int hold_low);
    logic [7:0] crc_field;
    logic       par, exp_c, exp_int;
    par       = (^d) ^ par_flip;
    crc_field = ref_crc(d) ^ crc_mask;
    exp_c     = crc_on && (crc_mask != 8'h00);
    exp_int   = !par_flip && !exp_c && stop_b;
    dv_cnt = 0; int_cnt = 0;
    crc_en_i = crc_on;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    if (crc_on) for (int i = 0; i < 8; i++) drive_bit(crc_field[i]);
    drive_bit(stop_b);
    if (!stop_b && hold_low > 0) begin
      repeat (hold_low) @(negedge clk_i);
      chk({tag, " busy_while_low"}, 32'(busy_o), 32'd0);
      chk({tag, " dv_while_low"}, 32'(dv_cnt), 32'd1);
    end
    rx_i = 1'b1;
    repeat (BIT_CLKS) @(negedge clk_i);
    $display("frame %s data=%02h crc_en=%0d par_flip=%0d crc_mask=%02h stop=%0d -> dv=%0d data_o=%02h p=%0d c=%0d f=%0d int=%0d",
             tag, d, crc_on, par_flip, crc_mask, stop_b, dv_cnt, cap_data, cap_p, cap_c, cap_f, int_cnt);
    chk({tag, " dv_count"}, 32'(dv_cnt), 32'd1);
    chk({tag, " data"}, 32'(cap_data), 32'(d));
    chk({tag, " parity_err"}, 32'(cap_p), 32'(par_flip));
    chk({tag, " crc_err"}, 32'(cap_c), 32'(exp_c));
    chk({tag, " frame_err"}, 32'(cap_f), 32'(!stop_b));
    chk({tag, " int_count"}, 32'(int_cnt), 32'(exp_int));
    if (exp_int) chk({tag, " int_delay"}, 32'(int_cyc - dv_cyc), 32'd1);
    chk({tag, " data_held"}, 32'(data_o), 32'(d));
    chk({tag, " busy_idle"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [7:0] rd, rmask;
    logic       rcrc, rpar, rstop;

    rst_ni = 1'b0; rx_i = 1'b1; crc_en_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset data_o", 32'(data_o), 32'h00);
    chk("reset flags", {29'd0, parity_err_o, crc_err_o, frame_err_o}, 32'd0);
    chk("reset pulses", {30'd0, data_valid_o, rx_int_o}, 32'd0);
    chk("reset busy", 32'(busy_o), 32'd0);
    rst_ni = 1'b1;
    repeat (BIT_CLKS) @(negedge clk_i);

    run_frame("A5_nocrc", 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, 0);
    run_frame("3C_crc", 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1, 0);
    run_frame("3C_crcbit3", 8'h3C, 1'b1, 1'b0, 8'h08, 1'b1, 0);
    run_frame("01_par0", 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 0);
    run_frame("77_stop0", 8'h77, 1'b0, 1'b0, 8'h00, 1'b0, 3 * BIT_CLKS);
    run_frame("C3_after_ferr", 8'hC3, 1'b0, 1'b0, 8'h00, 1'b1, 0);

    // Short low glitch in IDLE: START is entered, then abandoned.
    dv_cnt = 0; int_cnt = 0;
    rx_i = 1'b0;
    repeat (10) @(negedge clk_i);
    chk("glitch busy_high", 32'(busy_o), 32'd1);
    repeat (3 * TICK_DIV - 10) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (BIT_CLKS + 16) @(negedge clk_i);
    $display("glitch 3 ticks -> busy=%0d dv=%0d int=%0d", busy_o, dv_cnt, int_cnt);
    chk("glitch busy_low", 32'(busy_o), 32'd0);
    chk("glitch no_dv", 32'(dv_cnt + int_cnt), 32'd0);

    // Reset in the middle of data bit 4.
    dv_cnt = 0; int_cnt = 0;
    crc_en_i = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx_i = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk_i);
    rst_ni = 1'b0;
    rx_i = 1'b1;
    #1;
    chk("midrst data_o", 32'(data_o), 32'h00);
    chk("midrst outs", {26'd0, data_valid_o, parity_err_o, crc_err_o, frame_err_o, rx_int_o, busy_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk_i);
    $display("midframe reset -> busy=%0d dv=%0d int=%0d", busy_o, dv_cnt, int_cnt);
    chk("midrst no_pulse", 32'(dv_cnt + int_cnt), 32'd0);
    run_frame("5A_after_rst", 8'h5A, 1'b0, 1'b0, 8'h00, 1'b1, 0);

    for (int n = 0; n < 12; n++) begin
      rd    = 8'($urandom_range(0, 255));
      rcrc  = ($urandom_range(0, 1) == 1);
      rpar  = ($urandom_range(0, 3) == 0);
      rmask = (rcrc && $urandom_range(0, 3) == 0) ? 8'(8'h01 << $urandom_range(0, 7)) : 8'h00;
      rstop = ($urandom_range(0, 4) != 0);
      run_frame($sformatf("rand%0d", n), rd, rcrc, rpar, rmask, rstop, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
